// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the load/store unit (LS). Only one transaction is outstanding at a
// time. Each response goes back to the requester that won the grant. A
// watchdog aborts the transaction when memory stays silent too long.
//
// Optional build macro MEM_ARB_RR_EN: when defined, simultaneous requests
// alternate between the two requesters. When undefined, LS always wins
// contention.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic if_want;
  logic ls_want;
  logic pick_ls;
  logic pick_if;

  // Requests are masked while reset is asserted. This keeps every output low
  // during reset, even if a requester is already raising its request.
  assign if_want = if_req & rst;
  assign ls_want = ls_req & rst;

`ifdef MEM_ARB_RR_EN
  // This flag is 1 when LS won the most recent grant. Under contention, the
  // other requester is chosen next.
  logic last_ls_reg;
  assign pick_ls = ls_want & (~if_want | ~last_ls_reg);
`else
  // Fixed priority: the load/store unit wins whenever it is requesting.
  assign pick_ls = ls_want;
`endif
  assign pick_if = if_want & ~pick_ls;

  // Next-state logic. It also produces the grants and the routed responses.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_ls) begin
          ls_gnt     = 1'b1;
          state_next = WAIT_LS;
          cnt_next   = '0;
        end else if (pick_if) begin
          if_gnt     = 1'b1;
          state_next = WAIT_IF;
          cnt_next   = '0;
        end
      end
      WAIT_IF: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A real response takes precedence over a timeout in the same cycle.
        if (mem_rvalid) begin
          if_rvalid  = 1'b1;
          if_rdata   = mem_rdata;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          if_rvalid  = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_LS: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (mem_rvalid) begin
          ls_rvalid  = 1'b1;
          ls_rdata   = mem_rdata;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          ls_rvalid  = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory request fields are taken from the winning requester. An
  // instruction fetch is always a full-width read.
  assign mem_req  = if_gnt | ls_gnt;
  assign mem_we   = ls_gnt & ls_we;
  assign mem_addr = ls_gnt ? ls_addr : (if_gnt ? if_addr : '0);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign mem_be[gi]          = ls_gnt ? ls_be[gi] : if_gnt;
      assign mem_wdata[gi*8 +: 8] = ls_gnt ? ls_wdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // State and watchdog registers. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Record the winner of every grant, whether or not it was contested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls_reg <= 1'b0;
    end else if (if_gnt | ls_gnt) begin
      last_ls_reg <= ls_gnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// The bench first runs directed scenarios and then a long randomized phase.
// A transaction-level reference model supplies the expected outputs for
// every cycle. Compile with +define+MEM_ARB_RR_EN to exercise the
// alternating arbitration build.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [3:0]    ls_be = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          err;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Staged stimulus: these values are applied just after the next rising edge.
  logic          s_rst = 1'b0;
  logic          s_if_req = 1'b0;
  logic [AW-1:0] s_if_addr = '0;
  logic          s_ls_req = 1'b0;
  logic          s_ls_we = 1'b0;
  logic [3:0]    s_ls_be = '0;
  logic [AW-1:0] s_ls_addr = '0;
  logic [DW-1:0] s_ls_wdata = '0;

  // Memory behaviour: 0 = random latency, >0 = fixed latency, <0 = no reply.
  int            fixed_lat = 0;
  bit            use_fixed_data = 1'b0;
  logic [DW-1:0] fixed_data = '0;
  bit            force_rvalid = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t rsp_q[$];

  // The reference model tracks only the transaction: whether one is
  // outstanding, who owns it, when it was granted, and who won last.
  int cyc = 0;
  bit m_busy = 1'b0;
  bit m_owner_ls = 1'b0;
  int m_gcyc = 0;
  bit m_last_ls = 1'b0;
  int txn = 0;

  logic          e_if_gnt, e_ls_gnt, e_mem_req, e_mem_we;
  logic [3:0]    e_mem_be;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic          e_if_rvalid, e_ls_rvalid, e_err;
  logic [DW-1:0] e_if_rdata, e_ls_rdata;

  task automatic schedule(input bit is_write);
    int   lat;
    int   pick;
    rsp_t r;
    if (fixed_lat != 0) begin
      lat = fixed_lat;
    end else begin
      pick = int'($urandom_range(15, 0));
      if (pick <= 10)      lat = int'($urandom_range(5, 1));
      else if (pick <= 12) lat = TO;
      else if (pick == 13) lat = TO + 2;
      else if (pick == 14) lat = -1;
      else                 lat = TO - 1;
    end
    if (lat > 0) begin
      r.due  = cyc + lat;
      r.data = is_write ? 32'h0 : (use_fixed_data ? fixed_data : $urandom);
      rsp_q.push_back(r);
    end
  endtask

  task automatic model_check();
    bit win_ls;
    e_if_gnt = 0; e_ls_gnt = 0; e_mem_req = 0; e_mem_we = 0;
    e_mem_be = '0; e_mem_addr = '0; e_mem_wdata = '0;
    e_if_rvalid = 0; e_ls_rvalid = 0; e_err = 0;
    e_if_rdata = '0; e_ls_rdata = '0;
    if (!rst) begin
      m_busy = 1'b0;
      m_last_ls = 1'b0;
      rsp_q.delete();
    end else if (!m_busy) begin
      if (if_req || ls_req) begin
        if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
          win_ls = !m_last_ls;
`else
          win_ls = 1'b1;
`endif
        end else begin
          win_ls = ls_req;
        end
        e_mem_req = 1'b1;
        if (win_ls) begin
          e_ls_gnt = 1'b1; e_mem_we = ls_we; e_mem_be = ls_be;
          e_mem_addr = ls_addr; e_mem_wdata = ls_wdata;
        end else begin
          e_if_gnt = 1'b1; e_mem_be = 4'hF; e_mem_addr = if_addr;
        end
        m_busy = 1'b1; m_owner_ls = win_ls; m_gcyc = cyc; m_last_ls = win_ls;
        schedule(win_ls && ls_we);
      end
    end else begin
      if (mem_rvalid || (cyc - m_gcyc == TO)) begin
        if (m_owner_ls) begin
          e_ls_rvalid = 1'b1;
          e_ls_rdata = mem_rvalid ? mem_rdata : '0;
        end else begin
          e_if_rvalid = 1'b1;
          e_if_rdata = mem_rvalid ? mem_rdata : '0;
        end
        e_err = !mem_rvalid;
        m_busy = 1'b0;
        txn++;
        $display("txn %0d %s lat=%0d rdata=%h err=%0b", txn, m_owner_ls ? "LS" : "IF",
                 cyc - m_gcyc, mem_rvalid ? mem_rdata : 32'h0, !mem_rvalid);
      end
    end
    check("if_gnt", if_gnt, e_if_gnt);
    check("ls_gnt", ls_gnt, e_ls_gnt);
    check("mem_req", mem_req, e_mem_req);
    check("mem_we", mem_we, e_mem_we);
    check("mem_be", mem_be, e_mem_be);
    check("mem_addr", mem_addr, e_mem_addr);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("if_rvalid", if_rvalid, e_if_rvalid);
    check("if_rdata", if_rdata, e_if_rdata);
    check("ls_rvalid", ls_rvalid, e_ls_rvalid);
    check("ls_rdata", ls_rdata, e_ls_rdata);
    check("err", err, e_err);
  endtask

  // Each step is one clock: apply staged inputs after the rising edge,
  // let the memory answer, then compare against the model at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    rst = s_rst;
    if_req = s_if_req; if_addr = s_if_addr;
    ls_req = s_ls_req; ls_we = s_ls_we; ls_be = s_ls_be;
    ls_addr = s_ls_addr; ls_wdata = s_ls_wdata;
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    for (int i = rsp_q.size() - 1; i >= 0; i--) begin
      if (rsp_q[i].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata = rsp_q[i].data;
        rsp_q.delete(i);
      end
    end
    if (force_rvalid) mem_rvalid = 1'b1;
    @(negedge clk);
    model_check();
    cyc++;
  endtask

  initial begin
    logic [3:0] cont_exp;
    int         grants;
    int         budget;

    // Reset with both requests already high: every output must stay low.
    s_rst = 1'b0; s_if_req = 1'b1; s_ls_req = 1'b1;
    repeat (3) step();
    check("rst_if_gnt", if_gnt, 1'b0);
    check("rst_ls_gnt", ls_gnt, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);

    // IF read at 0x40 with a memory latency of 3.
    s_rst = 1'b1; s_ls_req = 1'b0; s_if_req = 1'b1; s_if_addr = 32'h40;
    fixed_lat = 3; use_fixed_data = 1'b1; fixed_data = 32'h00500093;
    step();
    check("ifrd_gnt", if_gnt, 1'b1);
    check("ifrd_memreq", mem_req, 1'b1);
    check("ifrd_addr", mem_addr, 32'h40);
    s_if_req = 1'b0;
    repeat (2) step();
    step();
    check("ifrd_rvalid", if_rvalid, 1'b1);
    check("ifrd_rdata", if_rdata, 32'h00500093);

    // LS write; the write acknowledgement carries zero data.
    s_ls_req = 1'b1; s_ls_we = 1'b1; s_ls_be = 4'b0011;
    s_ls_addr = 32'h100; s_ls_wdata = 32'hDEADBEEF; fixed_lat = 2;
    step();
    check("lswr_we", mem_we, 1'b1);
    check("lswr_be", mem_be, 4'b0011);
    check("lswr_wdata", mem_wdata, 32'hDEADBEEF);
    s_ls_req = 1'b0;
    step();
    step();
    check("lswr_rvalid", ls_rvalid, 1'b1);
    check("lswr_rdata", ls_rdata, 32'h0);

    // Reset in the middle of an LS read while memory answers.
    s_ls_req = 1'b1; s_ls_we = 1'b0; s_ls_be = 4'hF; fixed_lat = -1;
    step();
    check("rstls_gnt", ls_gnt, 1'b1);
    s_ls_req = 1'b0;
    step();
    s_rst = 1'b0; force_rvalid = 1'b1;
    step();
    check("rstls_rvalid", ls_rvalid, 1'b0);
    force_rvalid = 1'b0;
    step();
    s_rst = 1'b1;
    step();
    check("post_rst_memreq", mem_req, 1'b0);
    check("post_rst_err", err, 1'b0);
    s_if_req = 1'b1; s_if_addr = 32'h80; fixed_lat = 1;
    step();
    check("post_rst_idle_gnt", if_gnt, 1'b1);
    s_if_req = 1'b0;
    step();

    // Contention: both requests are held high for four grants.
`ifdef MEM_ARB_RR_EN
    cont_exp = 4'b0101;
`else
    cont_exp = 4'b1111;
`endif
    s_if_req = 1'b1; s_ls_req = 1'b1; fixed_lat = 1;
    grants = 0; budget = 40;
    while (grants < 4 && budget > 0) begin
      step();
      budget--;
      if (if_gnt || ls_gnt) begin
        check($sformatf("cont_gnt%0d_ls", grants), ls_gnt, cont_exp[grants]);
        grants++;
      end
    end
    if (grants < 4) check("cont_budget", 1'b0, 1'b1);
    s_if_req = 1'b0; s_ls_req = 1'b0;
    repeat (2) step();

    // Timeout: memory never answers an IF read.
    s_if_req = 1'b1; s_if_addr = 32'h200; fixed_lat = -1;
    step();
    check("to_gnt", if_gnt, 1'b1);
    s_if_req = 1'b0;
    repeat (TO - 1) step();
    step();
    check("to_rvalid", if_rvalid, 1'b1);
    check("to_err", err, 1'b1);
    check("to_rdata", if_rdata, 32'h0);
    // Grants resume on the very next cycle. This grant's reply lands on the
    // timeout cycle.
    s_if_req = 1'b1; fixed_lat = TO; fixed_data = 32'hCAFEF00D;
    step();
    check("to_resume_gnt", if_gnt, 1'b1);
    s_if_req = 1'b0;
    repeat (TO - 1) step();
    step();
    check("edge_rvalid", if_rvalid, 1'b1);
    check("edge_err", err, 1'b0);
    check("edge_rdata", if_rdata, 32'hCAFEF00D);
    // A stray memory response while idle is ignored.
    force_rvalid = 1'b1;
    step();
    check("stray_if_rvalid", if_rvalid, 1'b0);
    check("stray_ls_rvalid", ls_rvalid, 1'b0);
    force_rvalid = 1'b0;
    step();

    // Randomized traffic from both requesters with random memory latency.
    fixed_lat = 0; use_fixed_data = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (s_if_req ? e_if_gnt : ($urandom_range(2, 0) == 0)) begin
        s_if_req = (s_if_req && e_if_gnt) ? 1'($urandom_range(1, 0)) : 1'b1;
        s_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (s_ls_req ? e_ls_gnt : ($urandom_range(2, 0) == 0)) begin
        s_ls_req = (s_ls_req && e_ls_gnt) ? 1'($urandom_range(1, 0)) : 1'b1;
        s_ls_we = 1'($urandom_range(1, 0));
        s_ls_be = 4'($urandom_range(15, 0));
        s_ls_addr = $urandom;
        s_ls_wdata = $urandom;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
